// File: rtl/sfx_pkg.sv
// Shared types and constants for the sound-effect sequencer:
// state/effect encoding, counter widths and the noise LFSR definition.
package sfx_pkg;

    localparam int PRE_W  = 17;
    localparam int DUR_W  = 9;
    localparam int HALF_W = 20;

    localparam logic [1:0] EFF_IDLE = 2'b00;
    localparam logic [1:0] EFF_SHOT = 2'b01;
    localparam logic [1:0] EFF_HIT  = 2'b10;

    // The state encoding doubles as the Effect output code.
    typedef enum logic [1:0] {
        ST_IDLE = EFF_IDLE,
        ST_SHOT = EFF_SHOT,
        ST_HIT  = EFF_HIT
    } sfx_state_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 on a right-shifting register land on bits 0,2,3,5.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {^(cur & LFSR_TAPS), cur[15:1]};
    endfunction

endpackage

// File: rtl/sfx_tone_gen.sv
// Half-period counter and square-wave register; strobes once per elapsed half-period.
module sfx_tone_gen
    import sfx_pkg::*;
(
    input  logic              clk_sys,
    input  logic              rst_b,
    input  logic              clear,
    input  logic              enable,
    input  logic [HALF_W-1:0] half,
    output logic              toggle_strobe,
    output logic              sq_out
);

    logic [HALF_W-1:0] cnt_q, cnt_d;
    logic              sq_q, sq_d;
    logic              at_end;

    assign at_end        = (cnt_q == half - HALF_W'(1));
    assign toggle_strobe = enable && !clear && at_end;

    always_comb begin
        cnt_d = cnt_q;
        sq_d  = sq_q;
        if (clear) begin
            cnt_d = '0;
            sq_d  = 1'b0;
        end else if (enable) begin
            if (at_end) begin
                cnt_d = '0;
                sq_d  = ~sq_q;
            end else begin
                cnt_d = cnt_q + HALF_W'(1);
            end
        end
    end

    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            cnt_q <= '0;
            sq_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sq_q  <= sq_d;
        end
    end

    assign sq_out = sq_q;

endmodule

// File: rtl/sfx_sequencer.sv
// Sound-effect sequencer: synchronises shot/collision events, prioritises effects, drives the audio pin.
// Build option SFX_NOISE_EN: the collision effect plays LFSR noise instead of a square tone.
//
// state | meaning
// IDLE  | silent, all counters held at zero
// SHOT  | falling-pitch tone for SHOT_MS ticks
// HIT   | collision tone/noise for HIT_MS ticks, only a new hit restarts it
module sfx_sequencer
    import sfx_pkg::*;
#(
    parameter int TICK_DIV   = 100000,
    parameter int SHOT_MS    = 120,
    parameter int HIT_MS     = 250,
    parameter int SHOT_HALF0 = 50000,
    parameter int SHOT_STEP  = 400,
    parameter int HIT_HALF   = 12500
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Shot,
    input  logic       Collision,
    output logic       Pin,
    output logic       Busy,
    output logic [1:0] Effect
);

    localparam logic [PRE_W-1:0]  TICK_LAST      = PRE_W'(TICK_DIV - 1);
    localparam logic [DUR_W-1:0]  SHOT_LAST      = DUR_W'(SHOT_MS - 1);
    localparam logic [DUR_W-1:0]  HIT_LAST       = DUR_W'(HIT_MS - 1);
    localparam logic [HALF_W-1:0] SHOT_HALF_INIT = HALF_W'(SHOT_HALF0);
    localparam logic [HALF_W-1:0] HIT_HALF_INIT  = HALF_W'(HIT_HALF);
    localparam logic [HALF_W:0]   STEP_EXT       = (HALF_W + 1)'(SHOT_STEP);

    // [0] metastability stage, [1] synchronised level, [2] previous level
    logic [2:0]        shot_sync_q, shot_sync_d;
    logic [2:0]        hit_sync_q, hit_sync_d;
    logic              shot_ev_q, shot_ev_d;
    logic              hit_ev_q, hit_ev_d;

    sfx_state_e        state_q, state_d;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [DUR_W-1:0]  dur_q, dur_d;
    logic [HALF_W-1:0] half_q, half_d;
    logic [HALF_W:0]   half_sum;
    logic              restart, clear, active, tick_wrap, expire;
    logic              toggle_strobe, sq_out;

    always_comb begin
        shot_sync_d = {shot_sync_q[1:0], Shot};
        hit_sync_d  = {hit_sync_q[1:0], Collision};
        shot_ev_d   = shot_sync_q[1] & ~shot_sync_q[2];
        hit_ev_d    = hit_sync_q[1] & ~hit_sync_q[2];
    end

    assign active    = (state_q != ST_IDLE);
    assign tick_wrap = active && (pre_q == TICK_LAST);
    assign expire    = tick_wrap && (dur_q == ((state_q == ST_HIT) ? HIT_LAST : SHOT_LAST));

    always_comb begin
        state_d = state_q;
        restart = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (hit_ev_q) begin
                    state_d = ST_HIT;
                    restart = 1'b1;
                end else if (shot_ev_q) begin
                    state_d = ST_SHOT;
                    restart = 1'b1;
                end
            end
            ST_SHOT: begin
                if (hit_ev_q) begin
                    state_d = ST_HIT;
                    restart = 1'b1;
                end else if (shot_ev_q) begin
                    state_d = ST_SHOT;
                    restart = 1'b1;
                end else if (expire) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HIT: begin
                if (hit_ev_q) begin
                    state_d = ST_HIT;
                    restart = 1'b1;
                end else if (expire) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Entry, restart and the return to IDLE all zero the counters and Pin.
    assign clear    = restart || (state_d == ST_IDLE);
    assign half_sum = {1'b0, half_q} + STEP_EXT;

    always_comb begin
        pre_d  = pre_q;
        dur_d  = dur_q;
        half_d = half_q;
        if (clear) begin
            pre_d = '0;
            dur_d = '0;
        end else if (tick_wrap) begin
            pre_d = '0;
            dur_d = dur_q + DUR_W'(1);
        end else begin
            pre_d = pre_q + PRE_W'(1);
        end

        if (restart) begin
            half_d = (state_d == ST_HIT) ? HIT_HALF_INIT : SHOT_HALF_INIT;
        end else if (state_d == ST_IDLE) begin
            half_d = '0;
        end else if ((state_q == ST_SHOT) && tick_wrap) begin
            half_d = half_sum[HALF_W] ? '1 : half_sum[HALF_W-1:0];
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            shot_sync_q <= '0;
            hit_sync_q  <= '0;
            shot_ev_q   <= 1'b0;
            hit_ev_q    <= 1'b0;
            state_q     <= ST_IDLE;
            pre_q       <= '0;
            dur_q       <= '0;
            half_q      <= '0;
        end else begin
            shot_sync_q <= shot_sync_d;
            hit_sync_q  <= hit_sync_d;
            shot_ev_q   <= shot_ev_d;
            hit_ev_q    <= hit_ev_d;
            state_q     <= state_d;
            pre_q       <= pre_d;
            dur_q       <= dur_d;
            half_q      <= half_d;
        end
    end

    sfx_tone_gen u_tone (
        .clk_sys       (Clk),
        .rst_b         (Reset_n),
        .clear         (clear),
        .enable        (active),
        .half          (half_q),
        .toggle_strobe (toggle_strobe),
        .sq_out        (sq_out)
    );

`ifdef SFX_NOISE_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic        noise_q, noise_d;
    logic        noise_adv;

    // The LFSR keeps running across effects so consecutive hits sound different.
    assign noise_adv = toggle_strobe && (state_q == ST_HIT);

    always_comb begin
        lfsr_d  = noise_adv ? lfsr_next(lfsr_q) : lfsr_q;
        noise_d = clear ? 1'b0 : (noise_adv ? lfsr_d[0] : noise_q);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            lfsr_q  <= LFSR_SEED;
            noise_q <= 1'b0;
        end else begin
            lfsr_q  <= lfsr_d;
            noise_q <= noise_d;
        end
    end

    assign Pin = (state_q == ST_HIT) ? noise_q : sq_out;
`else
    logic strobe_unused;
    assign strobe_unused = toggle_strobe;
    assign Pin           = sq_out;
`endif

    assign Busy   = active;
    assign Effect = state_q;

endmodule

// File: doc/sfx_sequencer.md
# sfx_sequencer

Sound-effect sequencer between the game logic and the piezo/audio pin on the PMOD header. It consumes the bullet block's shot and collision indications, which arrive from the slow game clock domain. It runs a small state machine that selects and prioritises effects, and synthesises a timed square-wave or noise waveform on a single output pin. The board clock drives it.

## Interface
- `TICK_DIV`, 100000: Clk cycles per 1 ms effect tick.
- `SHOT_MS`, 120: shot effect duration in ticks.
- `HIT_MS`, 250: collision effect duration in ticks.
- `SHOT_HALF0`, 50000: initial shot half-period in Clk cycles (1 kHz at 100 MHz).
- `SHOT_STEP`, 400: half-period increment per tick (falling pitch).
- `HIT_HALF`, 12500: collision half-period / noise step in Clk cycles.

Ports:
- `Clk` input 1: board clock (100 MHz). Single clock for the whole block.
- `Reset_n` input 1: asynchronous, active-low reset.
- `Shot` input 1: bullet-fired level/pulse, game-clock domain, asynchronous to Clk.
- `Collision` input 1: bullet/alien hit level/pulse, asynchronous to Clk.
- `Pin` output 1: audio waveform.
- `Busy` output 1: an effect is playing.
- `Effect` output 2: 00 idle, 01 shot, 10 hit.

## Operation
- Shot and Collision each pass through a 2-FF synchroniser. A rising-edge detect follows, giving one-cycle `shot_ev` and `hit_ev`.
- FSM states are IDLE, SHOT, HIT.
  - IDLE: `hit_ev` goes to HIT. `shot_ev` alone goes to SHOT. Both together go to HIT.
  - SHOT: `hit_ev` goes to HIT (preempt, restart). `shot_ev` restarts SHOT. Duration expiry goes to IDLE.
  - HIT: `hit_ev` restarts HIT. `shot_ev` is ignored. Duration expiry goes to IDLE.
- Entry or restart does all of the following:
  - clears tick prescaler, duration counter and half-period counter;
  - loads the half-period (SHOT_HALF0 or HIT_HALF);
  - forces Pin to 0.
- Tick prescaler (17 b) counts 0..TICK_DIV-1 while not IDLE. Each wrap increments the duration counter (9 b).
- Expiry occurs when the duration counter equals SHOT_MS-1 (or HIT_MS-1) at a wrap.
- SHOT tone:
  - Half-period counter (20 b) counts 0..half-1.
  - At half-1, Pin toggles and the counter clears.
  - Each tick adds SHOT_STEP to half, saturating at 2^20-1.
- HIT: behaviour depends on SFX_NOISE_EN (see Configuration).
- IDLE: Pin held 0, all counters held 0.
- Busy is 1 exactly when state is not IDLE.
- Effect equals the state encoding.
- Input levels held high produce no further events.

## Timing
- Reset values: Pin 0, Busy 0, Effect 00, state IDLE, LFSR 16'hACE1, all counters 0.
- Input rising edge sampled at Clk edge n: `*_ev` high at n+2, state/Busy/Effect updated at n+3.
- First Pin toggle occurs `half` cycles after state entry.
- Effect length is exactly DUR×TICK_DIV cycles from entry to IDLE. DUR is SHOT_MS or HIT_MS.
- Restart mid-effect takes effect on the same cycle as the event. No glitch: Pin goes to 0 on that cycle.
- Reset_n assertion mid-effect clears everything immediately (asynchronous). Release is synchronous to Clk.

## Configuration
- `SFX_NOISE_EN` defined:
  - In HIT, every HIT_HALF cycles the 16-bit Fibonacci LFSR advances (taps 16,14,13,11).
  - Pin takes `lfsr[0]`.
  - LFSR is not reset on effect entry.
- `SFX_NOISE_EN` undefined:
  - HIT is a plain square wave toggling every HIT_HALF cycles.
  - No LFSR is instantiated.

## Structure
- Package `sfx_pkg` holds:
  - the state enum (IDLE/SHOT/HIT) and Effect codes;
  - the LFSR seed 16'hACE1 and tap mask;
  - counter width constants (17/9/20).
- Sub-module `sfx_tone_gen` holds the half-period counter and Pin toggle register.
  - Inputs: `clear`, `half`, `enable`.
  - Output: `toggle_strobe`.
- The FSM and the tick/duration counters stay in the top.

## Test plan
Bench parameters: TICK_DIV=10, SHOT_MS=5, SHOT_HALF0=4, SHOT_STEP=1, HIT_MS=8, HIT_HALF=3.

1. Reset:
   - Reset_n low with inputs toggling: Pin=0, Busy=0, Effect=00 throughout.
   - After release, LFSR=16'hACE1.
2. Single shot:
   - Shot rising at cycle 0: Effect=01 at cycle 3.
   - Pin toggles every 4 cycles, then every 5 after the first tick.
   - Busy falls exactly 50 cycles after entry.
3. Shot preempted by hit:
   - Collision rises 20 cycles into a shot: Effect=10 three cycles later, Pin forced 0.
   - Busy lasts 80 cycles from HIT entry.
4. Simultaneous edges: Shot and Collision rise together from IDLE, giving Effect=10.
5. Shot during hit: Shot pulse mid-HIT leaves Effect=10 and the HIT end time unchanged.
6. Hit waveform:
   - With SFX_NOISE_EN, Pin follows the LFSR reference model every 3 cycles.
   - Without it, Pin toggles every 3 cycles.
   - Held-high Collision produces no retrigger.
